wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: funnels five execute-stage result sources onto
// NR_WB_PORTS registered scoreboard write ports with round-robin priority.
// Results that lose arbitration wait in small per-source FIFOs.

package wb_arbiter_pkg;
  typedef struct packed {
    logic [7:0]  cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_SRC        = 5,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic       [NR_SRC-1:0]                     src_valid_i,
  input  logic       [NR_SRC-1:0][TRANS_ID_BITS-1:0]  src_trans_id_i,
  input  logic       [NR_SRC-1:0][63:0]               src_result_i,
  input  exception_t [NR_SRC-1:0]                     src_exception_i,
  output logic       [NR_WB_PORTS-1:0]                wb_valid_o,
  output logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic       [NR_WB_PORTS-1:0][63:0]          wb_result_o,
  output exception_t [NR_WB_PORTS-1:0]                wb_exception_o,
  output logic                                        issue_stall_o,
  output logic                                        overflow_o
);

  localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NP_W  = $clog2(NR_WB_PORTS + 1);

  localparam logic [SRC_W:0]   NSRC_L  = (SRC_W+1)'(NR_SRC);
  localparam logic [SRC_W-1:0] LAST_L  = SRC_W'(NR_SRC - 1);
  localparam logic [NP_W-1:0]  NP_L    = NP_W'(NR_WB_PORTS);
  localparam logic [CNT_W-1:0] FULL_L  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_L = CNT_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [63:0]              data;
    exception_t               exc;
  } entry_t;

  entry_t                          mem_q [NR_SRC][FIFO_DEPTH];
  logic   [NR_SRC-1:0][PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic   [NR_SRC-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic   [SRC_W-1:0]              rr_q, rr_d;
  logic                            ovf_q, ovf_d;
  logic   [NR_WB_PORTS-1:0]        wbv_q, wbv_d;
  entry_t [NR_WB_PORTS-1:0]        wbe_q, wbe_d;

  entry_t [NR_SRC-1:0]             in_e, cand_e;
  logic   [NR_SRC-1:0]             cand_vld, grant, pop, wr_en;

  // Per-source candidate: FIFO head when buffered, otherwise the live input.
  always_comb begin
    in_e     = '0;
    cand_e   = '0;
    cand_vld = '0;
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      in_e[s].id   = src_trans_id_i[s];
      in_e[s].data = src_result_i[s];
      in_e[s].exc  = src_exception_i[s];
      cand_vld[s]  = (cnt_q[s] != '0) || src_valid_i[s];
      cand_e[s]    = (cnt_q[s] != '0) ? mem_q[s][rd_q[s]] : in_e[s];
    end
  end

  // Round-robin scan from rr_q, filling write ports in grant order.
  always_comb begin
    logic [SRC_W:0]   idx_w;
    logic [SRC_W-1:0] idx;
    logic [NP_W-1:0]  n;
    logic [SRC_W-1:0] last;
    logic             any;
    idx_w = '0;
    idx   = '0;
    n     = '0;
    last  = rr_q;
    any   = 1'b0;
    grant = '0;
    wbv_d = '0;
    wbe_d = '0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      idx_w = {1'b0, rr_q} + (SRC_W+1)'(k);
      if (idx_w >= NSRC_L) idx_w = idx_w - NSRC_L;
      idx = idx_w[SRC_W-1:0];
      if (cand_vld[idx] && (n != NP_L)) begin
        grant[idx] = 1'b1;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
          if (n == NP_W'(p)) begin
            wbv_d[p] = 1'b1;
            wbe_d[p] = cand_e[idx];
          end
        end
        n    = n + NP_W'(1);
        last = idx;
        any  = 1'b1;
      end
    end
    rr_d = rr_q;
    if (any) rr_d = (last == LAST_L) ? '0 : last + SRC_W'(1);
    if (flush_i) begin
      grant = '0;
      wbv_d = '0;
      wbe_d = '0;
      rr_d  = '0;
    end
  end

  // FIFO bookkeeping: pop granted heads, enqueue ungranted or non-bypassed inputs.
  always_comb begin
    logic push, drop;
    push  = 1'b0;
    drop  = 1'b0;
    pop   = '0;
    wr_en = '0;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    ovf_d = ovf_q;
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      pop[s]   = grant[s] && (cnt_q[s] != '0);
      push     = src_valid_i[s] && !(grant[s] && (cnt_q[s] == '0));
      drop     = push && (cnt_q[s] == FULL_L) && !pop[s];
      wr_en[s] = push && !drop && !flush_i;
      cnt_d[s] = cnt_q[s] + CNT_W'(wr_en[s]) - CNT_W'(pop[s]);
      rd_d[s]  = rd_q[s] + PTR_W'(pop[s]);
      wr_d[s]  = wr_q[s] + PTR_W'(wr_en[s]);
      if (drop && !flush_i) ovf_d = 1'b1;
    end
    if (flush_i) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end
  end

  // FIFO storage; contents need no reset since counts gate every read.
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      if (wr_en[s]) mem_q[s][wr_q[s]] <= in_e[s];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      rr_q  <= '0;
      ovf_q <= 1'b0;
      wbv_q <= '0;
      wbe_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      rr_q  <= rr_d;
      ovf_q <= ovf_d;
      wbv_q <= wbv_d;
      wbe_q <= wbe_d;
    end
  end

  // Output unpacking; stall looks only at registered counts.
  always_comb begin
    wb_valid_o     = wbv_q;
    wb_trans_id_o  = '0;
    wb_result_o    = '0;
    wb_exception_o = '0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      wb_trans_id_o[p]  = wbe_q[p].id;
      wb_result_o[p]    = wbe_q[p].data;
      wb_exception_o[p] = wbe_q[p].exc;
    end
    issue_stall_o = 1'b0;
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      if (cnt_q[s] >= STALL_L) issue_stall_o = 1'b1;
    end
    overflow_o = ovf_q;
  end

endmodule
